// File: rtl/sr16_pkg.sv
// sr16_pkg: shared types and constants for the sr16 serial-load transmitter.
//   sr16_state_e : transmitter FSM states (IDLE, PRESET, SHIFT)
//   SR16_WIDTH   : default frame width in bits
package sr16_pkg;

  localparam int unsigned SR16_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRESET = 2'd1,
    ST_SHIFT  = 2'd2
  } sr16_state_e;

endpackage

// File: rtl/sr16_clkgen.sv
// sr16_clkgen: serial-clock phase divider for the sr16 transmitter.
// One serial period is 2*CLK_DIV system clocks: CLK_DIV low, then CLK_DIV high.
// While disabled the divider sits at the start of the low phase, so every
// enable begins a fresh low phase.
// Ports:
//   clk_i        system clock
//   rst_i        synchronous active-high reset
//   en_i         run the divider (held at phase start when low)
//   rise_tick_o  strobe in the cycle before the serial clock must rise
//   fall_tick_o  strobe in the cycle before the serial clock must fall
module sr16_clkgen
  import sr16_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic rise_tick_o,
  output logic fall_tick_o
);

  localparam int unsigned     CW      = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0]   RISE_AT = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]   FALL_AT = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0]   ONE     = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d       = '0;
    rise_tick_o = 1'b0;
    fall_tick_o = 1'b0;
    if (en_i) begin
      rise_tick_o = (cnt_q == RISE_AT);
      fall_tick_o = (cnt_q == FALL_AT);
      // Explicit restart at the end of the period; never relies on overflow.
      cnt_d       = (cnt_q == FALL_AT) ? '0 : cnt_q + ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sr16_serializer.sv
// sr16_serializer: transmit end of the 16b serial link into a divider's
// shift-register receiver. Accepts a parallel word over valid/ready and
// shifts it out MSB first with a generated serial clock, shift enable and
// output enable. soe_out is held low for the whole frame so the receiver
// never shows partial data.
// Build option: define SR16_TX_PRESET_EN to insert a one-serial-period
// PRESET phase (srst_out=1, sen_out=0, one sclk_out rising edge) before the
// shift; otherwise srst_out is tied low.
// Ports:
//   serdata_clock  system clock, posedge
//   serdata_reset  synchronous active-high reset
//   load_data      word to transmit, sampled on accept
//   load_valid     load_data is valid
//   load_ready     idle; accept = load_valid & load_ready
//   sclk_out       serial clock, idles low
//   sdata_out      serial data, MSB first
//   sen_out        receiver shift enable
//   soe_out        receiver output enable
//   srst_out       receiver register reset (preset build only)
//   done           one-cycle pulse at frame completion
module sr16_serializer
  import sr16_pkg::*;
#(
  parameter int unsigned WIDTH   = SR16_WIDTH,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic             serdata_clock,
  input  logic             serdata_reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sclk_out,
  output logic             sdata_out,
  output logic             sen_out,
  output logic             soe_out,
  output logic             srst_out,
  output logic             done
);

  localparam int unsigned    BCW       = $clog2(WIDTH + 1);
  localparam logic [BCW-1:0] BITS_INIT = BCW'(WIDTH);
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(1);

  sr16_state_e      state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]   bitcnt_q, bitcnt_d;   // bits still to be shifted
  logic             sclk_q, sclk_d;
  logic             sdata_q, sdata_d;
  logic             sen_q, sen_d;
  logic             soe_q, soe_d;
  logic             done_q, done_d;
`ifdef SR16_TX_PRESET_EN
  logic             srst_q, srst_d;
`endif

  logic accept;
  logic clk_en;
  logic rise_tick;
  logic fall_tick;

  assign load_ready = (state_q == ST_IDLE);
  assign accept     = load_valid & load_ready;
  assign clk_en     = (state_q != ST_IDLE);

  sr16_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk_i       (serdata_clock),
    .rst_i       (serdata_reset),
    .en_i        (clk_en),
    .rise_tick_o (rise_tick),
    .fall_tick_o (fall_tick)
  );

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    sclk_d   = sclk_q;
    sdata_d  = sdata_q;
    sen_d    = sen_q;
    soe_d    = soe_q;
    done_d   = 1'b0;
`ifdef SR16_TX_PRESET_EN
    srst_d   = srst_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shreg_d  = load_data;
          bitcnt_d = BITS_INIT;
          soe_d    = 1'b0;
`ifdef SR16_TX_PRESET_EN
          state_d  = ST_PRESET;
          srst_d   = 1'b1;
          sen_d    = 1'b0;
          sdata_d  = 1'b0;
`else
          // First bit is presented at the start of the first low phase.
          state_d  = ST_SHIFT;
          sen_d    = 1'b1;
          sdata_d  = load_data[WIDTH-1];
`endif
        end
      end

`ifdef SR16_TX_PRESET_EN
      ST_PRESET: begin
        if (rise_tick) begin
          sclk_d = 1'b1;
        end
        if (fall_tick) begin
          sclk_d  = 1'b0;
          srst_d  = 1'b0;
          sen_d   = 1'b1;
          sdata_d = shreg_q[WIDTH-1];
          state_d = ST_SHIFT;
        end
      end
`endif

      ST_SHIFT: begin
        if (rise_tick) begin
          sclk_d = 1'b1;
        end
        if (fall_tick) begin
          sclk_d = 1'b0;
          if (bitcnt_q == LAST_BIT) begin
            state_d  = ST_IDLE;
            sen_d    = 1'b0;
            soe_d    = 1'b1;
            done_d   = 1'b1;
            sdata_d  = 1'b0;
            bitcnt_d = '0;
          end else begin
            // sdata_q already shows shreg_q[WIDTH-1]; the next bit is one below.
            shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
            sdata_d  = shreg_q[WIDTH-2];
            bitcnt_d = bitcnt_q - LAST_BIT;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge serdata_clock) begin
    if (serdata_reset) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      sclk_q   <= 1'b0;
      sdata_q  <= 1'b0;
      sen_q    <= 1'b0;
      soe_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      sclk_q   <= sclk_d;
      sdata_q  <= sdata_d;
      sen_q    <= sen_d;
      soe_q    <= soe_d;
      done_q   <= done_d;
    end
  end

`ifdef SR16_TX_PRESET_EN
  always_ff @(posedge serdata_clock) begin
    if (serdata_reset) begin
      srst_q <= 1'b0;
    end else begin
      srst_q <= srst_d;
    end
  end
  assign srst_out = srst_q;
`else
  assign srst_out = 1'b0;
`endif

  assign sclk_out  = sclk_q;
  assign sdata_out = sdata_q;
  assign sen_out   = sen_q;
  assign soe_out   = soe_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sr16_serializer.sv
// Testbench for sr16_serializer: cycle-accurate behavioural model of the
// serial link output timing, loopback receivers, directed cases and a
// randomized stream with occasional resets.
module tb_sr16_serializer;
  import sr16_pkg::*;

  localparam int W = 16;
  localparam int C = 2;
`ifdef SR16_TX_PRESET_EN
  localparam int P = 2 * C;
`else
  localparam int P = 0;
`endif
  localparam int L = P + 2 * W * C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] load_data = '0;
  logic        load_valid = 1'b0;
  logic        load_ready, sclk_out, sdata_out, sen_out, soe_out, srst_out, done;

  logic [15:0] d1 = '0;
  logic        v1 = 1'b0;
  logic        rdy1, sclk1, sdata1, sen1, soe1, srst1, done1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sr16_serializer #(.WIDTH(W), .CLK_DIV(C)) dut (
    .serdata_clock (clk),
    .serdata_reset (rst),
    .load_data     (load_data),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
    .sclk_out      (sclk_out),
    .sdata_out     (sdata_out),
    .sen_out       (sen_out),
    .soe_out       (soe_out),
    .srst_out      (srst_out),
    .done          (done)
  );

  sr16_serializer #(.WIDTH(W), .CLK_DIV(1)) dut1 (
    .serdata_clock (clk),
    .serdata_reset (rst),
    .load_data     (d1),
    .load_valid    (v1),
    .load_ready    (rdy1),
    .sclk_out      (sclk1),
    .sdata_out     (sdata1),
    .sen_out       (sen1),
    .soe_out       (soe1),
    .srst_out      (srst1),
    .done          (done1)
  );

  // Loopback receivers clocked by the serial clock.
  logic [15:0] rx_sh = '0;
  logic [15:0] rx1_sh = '0;
  logic [15:0] rx_par, rx1_par;
  int rises = 0;
  int rises1 = 0;

  always @(posedge sclk_out) begin
    rises <= rises + 1;
    if (srst_out) rx_sh <= '0;
    else if (sen_out) rx_sh <= {rx_sh[14:0], sdata_out};
  end

  always @(posedge sclk1) begin
    rises1 <= rises1 + 1;
    if (srst1) rx1_sh <= '0;
    else if (sen1) rx1_sh <= {rx1_sh[14:0], sdata1};
  end

  assign rx_par  = soe_out ? rx_sh : '0;
  assign rx1_par = soe1 ? rx1_sh : '0;

  // Inputs as seen by the DUT at each rising edge, plus the edge number.
  int          s_n = 0;
  logic        s_rst = 1'b0;
  logic        s_v = 1'b0;
  logic [15:0] s_d = '0;

  always @(posedge clk) begin
    s_n   <= s_n + 1;
    s_rst <= rst;
    s_v   <= load_valid;
    s_d   <= load_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: outputs are a function of the offset since the accept
  // edge of the frame in flight.
  initial begin : model
    int          t0, k, j, b;
    logic        busy, soe_m, done_m, rdy_prev;
    logic [15:0] word;
    logic [6:0]  e, a;
    busy = 1'b0; soe_m = 1'b0; t0 = 0; word = '0;
    forever begin
      @(negedge clk);
      done_m   = 1'b0;
      rdy_prev = !busy;
      if (s_rst) begin
        busy  = 1'b0;
        soe_m = 1'b0;
      end else begin
        if (busy && (s_n - t0 == L)) begin
          busy = 1'b0; soe_m = 1'b1; done_m = 1'b1;
        end
        if (s_v && rdy_prev) begin
          busy = 1'b1; t0 = s_n; word = s_d;
        end
      end
      // e = {ready, sclk, sdata, sen, soe, srst, done}
      if (busy) begin
        k = s_n - t0;
        if (k < P) begin
          e = {1'b0, (k >= C), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        end else begin
          j = k - P;
          b = j / (2 * C);
          e = {1'b0, ((j % (2 * C)) >= C), word[W-1-b], 1'b1, 1'b0, 1'b0, 1'b0};
        end
      end else begin
        e = {1'b1, 1'b0, 1'b0, 1'b0, soe_m, 1'b0, done_m};
      end
      a = {load_ready, sclk_out, sdata_out, sen_out, soe_out, srst_out, done};
      chk($sformatf("outputs@edge%0d", s_n), 32'(a), 32'(e));
    end
  end

  task automatic send(input logic [15:0] w, output int acc_n);
    int g;
    g = 0;
    @(negedge clk);
    while (!load_ready && g < 1000) begin
      @(negedge clk);
      g++;
    end
    total++;
    if (!load_ready) begin
      bad++;
      $display("FAIL send_ready: load_ready=0 after 1000 cycles, required 1");
    end
    load_valid = 1'b1;
    load_data  = w;
    @(negedge clk);
    acc_n      = s_n;
    load_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, output int dn);
    dn = -1;
    for (int g = 0; g < 1000; g++) begin
      @(negedge clk);
      if (done) begin
        dn = s_n;
        break;
      end
    end
    total++;
    if (dn < 0) begin
      bad++;
      $display("FAIL %s: no done pulse within 1000 cycles, required one", name);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int a, a2, dn, r0, cnt, tog;
    logic prev;

    repeat (3) @(negedge clk);
    chk("reset_state", 32'({load_ready, sclk_out, sdata_out, sen_out, soe_out, srst_out, done}), 32'h40);
    rst = 1'b0;

    // 1: A5C3 MSB first, latency and loopback
    r0 = rises;
    send(16'hA5C3, a);
    wait_done("t1_done", dn);
    chk("t1_latency", 32'(dn - a), (P == 0) ? 32'd64 : 32'd68);
    chk("t1_rises", 32'(rises - r0), (P == 0) ? 32'd16 : 32'd17);
    chk("t1_rx", 32'(rx_par), 32'hA5C3);
    chk("t1_soe", 32'(soe_out), 32'd1);

    // 2: load_valid pulse mid-frame is ignored
    send(16'h1234, a);
    repeat (P + 2 * 5 * C) @(negedge clk);
    chk("t2_ready_busy", 32'(load_ready), 32'd0);
    load_valid = 1'b1;
    load_data  = 16'hFFFF;
    @(negedge clk);
    load_valid = 1'b0;
    load_data  = '0;
    wait_done("t2_done", dn);
    chk("t2_latency", 32'(dn - a), 32'(L));
    chk("t2_rx", 32'(rx_par), 32'h1234);

    // 3: reset at bit 7, with load_valid in the same cycle
    send(16'hBEEF, a);
    repeat (P + 2 * 7 * C) @(negedge clk);
    rst        = 1'b1;
    load_valid = 1'b1;
    load_data  = 16'h5555;
    @(negedge clk);
    rst        = 1'b0;
    load_valid = 1'b0;
    chk("t3_after_reset", 32'({load_ready, sclk_out, sdata_out, sen_out, soe_out, srst_out, done}), 32'h40);
    @(negedge clk);
    chk("t3_nothing_accepted", 32'({load_ready, sen_out}), 32'h2);
    send(16'h0001, a);
    wait_done("t3_done", dn);
    chk("t3_rx", 32'(rx_par), 32'h0001);

    // 4: valid held high, back-to-back accept on the done cycle
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = 16'h00FF;
    @(negedge clk);
    a = s_n;
    load_data = 16'hFF00;
    wait_done("t4_done1", dn);
    chk("t4_rx1", 32'(rx_par), 32'h00FF);
    chk("t4_soe_done", 32'(soe_out), 32'd1);
    @(negedge clk);
    a2 = s_n;
    load_valid = 1'b0;
    chk("t4_soe_next", 32'(soe_out), 32'd0);
    chk("t4_ready_next", 32'(load_ready), 32'd0);
    wait_done("t4_done2", dn);
    chk("t4_b2b_latency", 32'(dn - a2), 32'(L));
    chk("t4_rx2", 32'(rx_par), 32'hFF00);

`ifdef SR16_TX_PRESET_EN
    // 5: preset clears the receiver before the shift
    send(16'hFFFF, a);
    wait_done("t5_done1", dn);
    send(16'h0000, a);
    cnt = 1;  // the k=0 cycle after accept already has srst_out high
    dn  = -1;
    for (int g = 0; g < 1000; g++) begin
      @(negedge clk);
      if (srst_out && !sen_out) cnt++;
      if (done) begin
        dn = s_n;
        break;
      end
    end
    chk("t5_srst_cycles", 32'(cnt), 32'(2 * C));
    chk("t5_latency", 32'(dn - a), 32'(34 * C));
    chk("t5_rx", 32'(rx_par), 32'h0000);
`endif

    // Randomized stream; the model checks every cycle
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst        = ($urandom_range(0, 399) == 0);
      load_valid = ($urandom_range(0, 3) == 0);
      load_data  = 16'($urandom);
    end
    @(negedge clk);
    rst        = 1'b0;
    load_valid = 1'b0;
    send(16'h6C39, a);
    wait_done("rand_tail_done", dn);
    chk("rand_tail_rx", 32'(rx_par), 32'h6C39);

    // 6: CLK_DIV=1 instance, sclk toggles every cycle
    @(negedge clk);
    chk("t6_ready", 32'(rdy1), 32'd1);
    r0 = rises1;
    v1 = 1'b1;
    d1 = 16'h8001;
    @(negedge clk);
    a    = s_n;
    v1   = 1'b0;
    prev = sclk1;
    tog  = 0;
    dn   = -1;
    for (int g = 0; g < 500; g++) begin
      @(negedge clk);
      if (sclk1 != prev) tog++;
      prev = sclk1;
      if (done1) begin
        dn = s_n;
        break;
      end
    end
    chk("t6_latency", 32'(dn - a), (P == 0) ? 32'd32 : 32'd34);
    chk("t6_toggles", 32'(tog), (P == 0) ? 32'd32 : 32'd34);
    chk("t6_rises", 32'(rises1 - r0), (P == 0) ? 32'd16 : 32'd17);
    chk("t6_rx", 32'(rx1_par), 32'h8001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
